bpsk_symbol_decoder: RTL and testbench

BPSK_SYMBOL_DECODER -- requirements
Module: bpsk_symbol_decoder

---
 rtl/bpsk_pkg.sv | 24 ++
 rtl/bpsk_correlator.sv | 63 ++++++
 rtl/bpsk_symbol_decoder.sv | 101 ++++++++++
 tb/tb_bpsk_symbol_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared BPSK link constants and types, used by both the transmitter and the decoder.
// Holds the parameter defaults and the framing state encoding.
package bpsk_pkg;

  localparam int              BPSK_DATA_WIDTH  = 12;
  localparam int              BPSK_WAVELENGTH  = 64;
  localparam int              BPSK_PACKET_SIZE = 184;
  localparam logic [15:0]     BPSK_SYNC_WORD   = 16'hA5C3;

  // Transmitter side: nominal carrier amplitude and the phase shift that encodes a 0.
  localparam int              BPSK_TX_AMPLITUDE = 1000;
  localparam int              BPSK_TX_SHIFT     = BPSK_WAVELENGTH / 2;

  typedef enum logic {
    ST_SEARCH  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  // Accumulator width: one full period of worst-case samples plus a sign bit.
  function automatic int acc_width(input int data_width, input int wavelength);
    return data_width + $clog2(wavelength) + 1;
  endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Integrate-and-dump correlator against a square reference, one symbol per carrier period.
// Decision registered 1 clock after the last sample of a symbol; free-running, never stalls.
module bpsk_correlator
  import bpsk_pkg::*;
#(
  parameter  int DATA_WIDTH = BPSK_DATA_WIDTH,
  parameter  int WAVELENGTH = BPSK_WAVELENGTH,
  localparam int PHASE_W    = $clog2(WAVELENGTH),
  localparam int ACC_W      = acc_width(DATA_WIDTH, WAVELENGTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] amp_i,
  output logic                         dec_vld_o,
  output logic                         dec_bit_o,
  output logic                         bit_out_o,
  output logic                         bit_valid_o
);

  logic        [PHASE_W-1:0] phase_q, phase_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d;
  logic signed [ACC_W-1:0]   samp_ext;
  logic signed [ACC_W-1:0]   sum;
  logic                      last;
  logic                      bit_q, bit_d;
  logic                      vld_q, vld_d;

  always_comb begin
    samp_ext = ACC_W'(amp_i);
    // Second half of the period has a negative reference; WAVELENGTH is a power of two.
    sum      = phase_q[PHASE_W-1] ? (acc_q - samp_ext) : (acc_q + samp_ext);
    last     = (phase_q == PHASE_W'(WAVELENGTH - 1));

    phase_d   = phase_q + 1'b1;
    acc_d     = last ? '0 : sum;
    dec_vld_o = last;
    dec_bit_o = !sum[ACC_W-1] && (sum != '0);
    bit_d     = last ? dec_bit_o : bit_q;
    vld_d     = last;
    sum_d     = last ? sum : sum_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
    end
  end

  assign bit_out_o   = bit_q;
  assign bit_valid_o = vld_q;

endmodule

// File: rtl/bpsk_symbol_decoder.sv
// BPSK receiver: correlates the carrier into bits, hunts for the sync word, then captures one payload.
// bit_valid/packet_valid share the cycle after the symbol's last sample; no backpressure, timing never stalls.
module bpsk_symbol_decoder
  import bpsk_pkg::*;
#(
  parameter  int          DATA_WIDTH  = BPSK_DATA_WIDTH,
  parameter  int          WAVELENGTH  = BPSK_WAVELENGTH,
  parameter  int          PACKET_SIZE = BPSK_PACKET_SIZE,
  parameter  logic [15:0] SYNC_WORD   = BPSK_SYNC_WORD,
  localparam int          CNT_W       = $clog2(PACKET_SIZE + 1)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic signed [DATA_WIDTH-1:0] amp,
  output logic                         bit_out,
  output logic                         bit_valid,
  output logic                         locked,
  output logic [PACKET_SIZE-1:0]       packet,
  output logic                         packet_valid
);

  logic                   dec_vld;
  logic                   dec_bit;

  state_e                 state_q, state_d;
  logic [15:0]            sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PACKET_SIZE-1:0] payload_q, payload_d;
  logic [PACKET_SIZE-1:0] packet_q, packet_d;
  logic                   pkt_vld_q, pkt_vld_d;

  bpsk_correlator #(
    .DATA_WIDTH (DATA_WIDTH),
    .WAVELENGTH (WAVELENGTH)
  ) u_corr (
    .clock       (clock),
    .reset_n     (reset_n),
    .amp_i       (amp),
    .dec_vld_o   (dec_vld),
    .dec_bit_o   (dec_bit),
    .bit_out_o   (bit_out),
    .bit_valid_o (bit_valid)
  );

  // Framing acts on the combinational decision so packet_valid lines up with bit_valid.
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    packet_d  = packet_q;
    pkt_vld_d = 1'b0;

    if (dec_vld) begin
      case (state_q)
        ST_SEARCH: begin
          sync_d = {sync_q[14:0], dec_bit};
          if (sync_d == SYNC_WORD) begin
            state_d = ST_PAYLOAD;
            cnt_d   = '0;
          end
        end
        ST_PAYLOAD: begin
          payload_d = {payload_q[PACKET_SIZE-2:0], dec_bit};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(PACKET_SIZE - 1)) begin
            packet_d  = payload_d;
            pkt_vld_d = 1'b1;
            state_d   = ST_SEARCH;
            sync_d    = '0;
            cnt_d     = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_SEARCH;
      sync_q    <= '0;
      cnt_q     <= '0;
      payload_q <= '0;
      packet_q  <= '0;
      pkt_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
      packet_q  <= packet_d;
      pkt_vld_q <= pkt_vld_d;
    end
  end

  assign locked       = (state_q == ST_PAYLOAD);
  assign packet       = packet_q;
  assign packet_valid = pkt_vld_q;

endmodule

// File: tb/tb_bpsk_symbol_decoder.sv
// Directed bench for bpsk_symbol_decoder: a square-carrier transmitter drives hand-chosen symbols and frames.
module tb_bpsk_symbol_decoder;

  localparam int DW = 12;
  localparam int WL = 64;
  localparam int PS = 184;

  localparam int M_CAR  = 0;
  localparam int M_ZERO = 1;
  localparam int M_FULL = 2;

  localparam logic [255:0] SYNC  = 256'hA5C3;
  localparam logic [255:0] P_MSG = 256'h5468697320697320612074657374206d65737361676521;
  localparam logic [255:0] P_EMB = 256'h0123A5C3456789ABCDEFA5C3FEDCBA9876543210A5C3F0;
  localparam logic [255:0] P_TWO = 256'hDEADBEEFCAFEBABE0123456789ABCDEF13579BDF2468AC;

  logic                 clock;
  logic                 reset_n;
  logic signed [DW-1:0] amp;
  logic                 bit_out;
  logic                 bit_valid;
  logic                 locked;
  logic [PS-1:0]        packet;
  logic                 packet_valid;

  int n_chk  = 0;
  int n_pass = 0;

  int n_bv = 0, n_lock = 0, n_pv = 0, n_misalign = 0, n_glitch = 0;
  int lock_base;
  int s;
  logic pre_vld;
  logic [PS-1:0] prev_pkt = '0;

  bpsk_symbol_decoder #(
    .DATA_WIDTH  (DW),
    .WAVELENGTH  (WL),
    .PACKET_SIZE (PS),
    .SYNC_WORD   (16'hA5C3)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .amp          (amp),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .locked       (locked),
    .packet       (packet),
    .packet_valid (packet_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bit_valid) begin
      n_bv++;
      if (locked) n_lock++;
    end
    if (packet_valid) begin
      n_pv++;
      if (!bit_valid) n_misalign++;
    end
    if (reset_n && !packet_valid && packet !== prev_pkt) n_glitch++;
    prev_pkt = packet;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One symbol (or its first nsamp samples); inputs change 1ns after each active edge.
  task automatic send_sym(input int mode, input logic b, input int nsamp);
    int hi, lo, v;
    hi = (mode == M_FULL) ? 2047 : 1000;
    lo = (mode == M_FULL) ? -2048 : -1000;
    for (int i = 0; i < nsamp; i++) begin
      if (mode == M_ZERO) v = 0;
      else if (i < WL/2)  v = b ? hi : lo;
      else                v = b ? lo : hi;
      amp = DW'(v);
      if (i == WL-1) pre_vld = bit_valid;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bits(input logic [255:0] v, input int n);
    for (int i = n-1; i >= 0; i--) send_sym(M_CAR, v[i], WL);
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    amp     = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bit_out", 256'(bit_out), 256'd0);
    check("rst_bit_valid", 256'(bit_valid), 256'd0);
    check("rst_locked", 256'(locked), 256'd0);
    check("rst_packet", 256'(packet), 256'd0);
    check("rst_packet_valid", 256'(packet_valid), 256'd0);
    @(negedge clock);
    reset_n = 1'b1;

    send_sym(M_CAR, 1'b1, WL);
    s = dut.u_corr.sum_q;
    check("sym1_pre_valid", 256'(pre_vld), 256'd0);
    check("sym1_valid", 256'(bit_valid), 256'd1);
    check("sym1_bit", 256'(bit_out), 256'd1);
    check("sym1_sum", 256'(s), 256'(64000));

    send_sym(M_CAR, 1'b0, WL);
    s = dut.u_corr.sum_q;
    check("inv_bit", 256'(bit_out), 256'd0);
    check("inv_sum", 256'(s), 256'(-64000));

    send_sym(M_ZERO, 1'b0, WL);
    s = dut.u_corr.sum_q;
    check("zero_valid", 256'(bit_valid), 256'd1);
    check("zero_bit", 256'(bit_out), 256'd0);
    check("zero_sum", 256'(s), 256'd0);

    send_sym(M_FULL, 1'b1, WL);
    s = dut.u_corr.sum_q;
    check("full1_bit", 256'(bit_out), 256'd1);
    check("full1_sum", 256'(s), 256'(131040));

    send_sym(M_FULL, 1'b0, WL);
    s = dut.u_corr.sum_q;
    check("full0_bit", 256'(bit_out), 256'd0);
    check("full0_sum", 256'(s), 256'(-131040));
    settle();
    check("bit_valid_pulses", 256'(n_bv), 256'd5);
    check("no_early_lock", 256'(locked), 256'd0);

    send_bits(SYNC, 16);
    check("sync_locked", 256'(locked), 256'd1);
    send_bits(P_MSG, PS);
    check("msg_pv", 256'(packet_valid), 256'd1);
    check("msg_packet", 256'(packet), P_MSG);
    settle();
    check("msg_pv_count", 256'(n_pv), 256'd1);
    check("msg_locked_pulses", 256'(n_lock), 256'd184);
    check("msg_unlocked", 256'(locked), 256'd0);

    send_bits(SYNC, 16);
    send_bits(P_EMB, PS);
    check("emb_packet", 256'(packet), P_EMB);
    send_bits(SYNC, 16);
    send_bits(P_TWO, PS);
    check("two_packet", 256'(packet), P_TWO);
    send_bits(256'h0, 8);
    settle();
    check("two_pv_count", 256'(n_pv), 256'd3);
    check("two_locked_pulses", 256'(n_lock), 256'd552);
    check("idle_unlocked", 256'(locked), 256'd0);

    send_bits(SYNC, 16);
    send_bits(P_TWO >> (PS - 90), 90);
    send_sym(M_CAR, 1'b1, 20);
    check("abort_locked_before", 256'(locked), 256'd1);
    reset_n = 1'b0;
    #1;
    check("abort_rst_bit_out", 256'(bit_out), 256'd0);
    check("abort_rst_locked", 256'(locked), 256'd0);
    check("abort_rst_packet", 256'(packet), 256'd0);
    repeat (3) @(posedge clock);
    #1;
    check("abort_rst_bit_valid", 256'(bit_valid), 256'd0);
    check("abort_rst_packet_valid", 256'(packet_valid), 256'd0);
    @(negedge clock);
    reset_n = 1'b1;
    lock_base = n_lock;

    send_bits(SYNC, 16);
    send_bits(P_MSG, PS);
    check("post_rst_packet", 256'(packet), P_MSG);
    settle();
    check("post_rst_pv_count", 256'(n_pv), 256'd4);
    check("post_rst_locked_pulses", 256'(n_lock - lock_base), 256'd184);
    check("pv_aligned", 256'(n_misalign), 256'd0);
    check("packet_stable", 256'(n_glitch), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
